// File: rtl/slurm32_prefetch_pkg.sv
// rtl/slurm32_prefetch_pkg.sv - shared types and constants for the instruction prefetch buffer
package slurm32_prefetch_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } prefetch_state_t;

  localparam addr_t INSTR_STRIDE = 32'd4;

  // Word-granular address compare; byte offset bits are carried but never matter.
  function automatic logic same_word(input addr_t a, input addr_t b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/slurm32_prefetch_fifo.sv
// rtl/slurm32_prefetch_fifo.sv - synchronous word FIFO with flush, count and head output
module slurm32_prefetch_fifo
  import slurm32_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  word_t         push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output word_t         head
);

  word_t         mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  // Storage write; a flushed push is dropped so stale data never lands.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/slurm32_instruction_prefetch.sv
// rtl/slurm32_instruction_prefetch.sv - sequential instruction prefetch with redirect flush
module slurm32_instruction_prefetch
  import slurm32_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter addr_t       RESET_ADDR = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        instruction_request,
  input  logic [31:0] instruction_address,
  output logic        instruction_valid,
  output logic [31:0] instruction_out,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  prefetch_state_t state;
  addr_t           head_addr;
  addr_t           fetch_addr;
  logic [CW-1:0]   fifo_count;
  word_t           fifo_head;

  logic head_match;
  logic hit;
  logic redirect;
  logic issue;
  logic push;

  assign head_match = same_word(instruction_address, head_addr);
  assign hit        = instruction_request && (fifo_count != '0) && head_match;
  assign redirect   = instruction_request && !head_match;
  // The push slot is claimed at issue time, so checking occupancy in IDLE is enough.
  assign issue      = (state == IDLE) && (fifo_count < CW'(DEPTH)) && !redirect;
  assign push       = (state == FETCH) && mem_valid && !redirect;

  assign instruction_valid = hit;
  assign instruction_out   = hit ? fifo_head : '0;

  slurm32_prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (mem_data),
    .pop       (hit),
    .flush     (redirect),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Demand-side and fetch-side address tracking; a redirect restarts both at the new target.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_addr  <= RESET_ADDR;
      fetch_addr <= RESET_ADDR;
    end else begin
      if (redirect) begin
        head_addr <= instruction_address;
      end else if (hit) begin
        head_addr <= head_addr + INSTR_STRIDE;
      end
      if (redirect) begin
        fetch_addr <= instruction_address;
      end else if (issue) begin
        fetch_addr <= fetch_addr + INSTR_STRIDE;
      end
    end
  end

  // Read FSM: one outstanding read; a redirect mid-read lets the old read finish and drops it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= RESET_ADDR;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            mem_addr <= fetch_addr;
            mem_rd   <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (mem_valid) begin
            mem_rd <= 1'b0;
            state  <= IDLE;
          end else if (redirect) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_valid) begin
            mem_rd <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slurm32_instruction_prefetch.sv
// tb/tb_slurm32_instruction_prefetch.sv - self-checking bench for the instruction prefetch buffer
module tb_slurm32_instruction_prefetch;

  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h00000000;
  localparam logic [31:0] KEY        = 32'hA5A5A5A5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instruction_request = 1'b0;
  logic [31:0] instruction_address = 32'h0;
  logic        instruction_valid;
  logic [31:0] instruction_out;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = 32'h0;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  int          rises = 0;
  int          served = 0;
  logic        prev_rd = 1'b0;
  logic [31:0] exp_issue = RESET_ADDR;
  logic [31:0] last_rise = 32'h0;
  logic [31:0] pc = RESET_ADDR;

  slurm32_instruction_prefetch #(
    .DEPTH      (DEPTH),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .instruction_request (instruction_request),
    .instruction_address (instruction_address),
    .instruction_valid   (instruction_valid),
    .instruction_out     (instruction_out),
    .mem_rd              (mem_rd),
    .mem_addr            (mem_addr),
    .mem_valid           (mem_valid),
    .mem_data            (mem_data)
  );

  always #5 CLK = ~CLK;

  // Memory model: answers a held mem_rd after lat cycles with a one-cycle pulse.
  always @(posedge CLK) begin
    #1;
    if (RST || !mem_rd || mem_valid) begin
      mem_valid = 1'b0;
      wait_cnt  = 0;
    end else begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        mem_valid = 1'b1;
        mem_data  = mem_addr ^ KEY;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive, then sample at the falling edge against the model.
  task automatic step(input logic req, input logic [31:0] addr);
    logic redir;
    @(posedge CLK); #2;
    instruction_request = req;
    instruction_address = addr;
    #3;
    redir = req && (addr[31:2] != pc[31:2]);
    if (instruction_valid) begin
      chk("serve_req", 32'(req), 32'd1);
      chk("serve_seq", addr, pc);
      chk("serve_data", instruction_out, addr ^ KEY);
      pc = pc + 32'd4;
      served++;
    end else begin
      chk("out_zero", instruction_out, 32'd0);
    end
    if (mem_rd && !prev_rd) begin
      chk("issue_addr", mem_addr, exp_issue);
      last_rise = mem_addr;
      exp_issue = exp_issue + 32'd4;
      rises++;
    end
    prev_rd = mem_rd;
    if (redir) begin
      pc        = addr;
      exp_issue = addr;
    end
  endtask

  task automatic do_reset(input int l);
    @(posedge CLK); #2;
    RST = 1'b1;
    instruction_request = 1'b0;
    lat = l;
    @(posedge CLK); #5;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", mem_addr, RESET_ADDR);
    chk("rst_valid", 32'(instruction_valid), 32'd0);
    chk("rst_out", instruction_out, 32'd0);
    @(posedge CLK); #2;
    RST = 1'b0;
    pc = RESET_ADDR;
    exp_issue = RESET_ADDR;
    prev_rd = 1'b0;
  endtask

  task automatic wait_serve(input string tag, input int n, input int budget);
    int s0;
    int k;
    s0 = served;
    k = 0;
    while ((served - s0) < n && k < budget) begin
      step(1'b1, pc);
      k++;
    end
    chk(tag, 32'(served - s0), 32'(n));
  endtask

  initial begin
    int k;
    int s0;
    logic found;

    // Reset then randomized-demand stream at latency 1.
    do_reset(1);
    s0 = served;
    k = 0;
    while ((served - s0) < 24 && k < 400) begin
      step(1'($urandom_range(0, 3) != 0), pc);
      k++;
    end
    chk("stream_served", 32'(served - s0), 32'd24);

    // Fill to full with no demand, then one pop re-enables exactly one read.
    do_reset(2);
    rises = 0;
    repeat (20) step(1'b0, pc);
    chk("fill_rises", 32'(rises), 32'(DEPTH));
    chk("fill_idle", 32'(mem_rd), 32'd0);
    s0 = served;
    step(1'b1, pc);
    chk("fill_pop", 32'(served - s0), 32'd1);
    rises = 0;
    repeat (10) step(1'b0, pc);
    chk("refill_rises", 32'(rises), 32'd1);
    chk("refill_addr", last_rise, 32'(4 * DEPTH));

    // Redirect while idle and full.
    do_reset(1);
    repeat (20) step(1'b0, pc);
    wait_serve("consume_0_4", 2, 4);
    repeat (8) step(1'b0, pc);
    chk("pre_redir_idle", 32'(mem_rd), 32'd0);
    step(1'b1, 32'h100);
    rises = 0;
    step(1'b1, pc);
    step(1'b1, pc);
    chk("redir_idle_issue", 32'(rises), 32'd1);
    wait_serve("redir_idle_serve", 2, 12);

    // Redirect during an outstanding read: the old read is discarded.
    do_reset(4);
    rises = 0;
    k = 0;
    while (rises == 0 && k < 10) begin
      step(1'b0, pc);
      k++;
    end
    step(1'b0, pc);
    step(1'b1, 32'h200);
    k = 0;
    found = 1'b0;
    while (!found && k < 10) begin
      step(1'b1, pc);
      chk("discard_rd", 32'(mem_rd), 32'd1);
      chk("discard_addr", mem_addr, 32'h0);
      found = mem_valid;
      k++;
    end
    rises = 0;
    step(1'b1, pc);
    step(1'b1, pc);
    chk("discard_reissue", 32'(rises), 32'd1);
    wait_serve("discard_serve", 2, 20);

    // Redirect in the same cycle as mem_valid.
    do_reset(2);
    rises = 0;
    k = 0;
    while (rises == 0 && k < 10) begin
      step(1'b0, pc);
      k++;
    end
    step(1'b1, 32'h300);
    chk("coinc_rd", 32'(mem_rd), 32'd1);
    rises = 0;
    step(1'b1, pc);
    chk("coinc_no_push", 32'(instruction_valid), 32'd0);
    step(1'b1, pc);
    chk("coinc_reissue", 32'(rises), 32'd1);
    wait_serve("coinc_serve", 2, 12);

    // Reset while reading 0x40, then fetching restarts at the reset address.
    do_reset(3);
    found = 1'b0;
    k = 0;
    while (!found && k < 300) begin
      step(1'b1, pc);
      found = mem_rd && (mem_addr == 32'h40);
      k++;
    end
    chk("found_40", 32'(found), 32'd1);
    do_reset(3);
    wait_serve("restart_serve", 2, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
